// File: rtl/qdec_pkg.sv
// Shared phase codes, transition classes and the classifier for the quadrature decoder.
package qdec_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_FWD     = 2'd1,
        TR_REV     = 2'd2,
        TR_ILLEGAL = 2'd3
    } tr_e;

    // Forward successor along 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    function automatic tr_e classify(input logic [1:0] prev, input logic [1:0] cur);
        tr_e tr;
        if (cur == prev) begin
            tr = TR_NONE;
        end else if (cur == next_fwd(prev)) begin
            tr = TR_FWD;
        end else if (prev == next_fwd(cur)) begin
            tr = TR_REV;
        end else begin
            tr = TR_ILLEGAL;
        end
        return tr;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Per-phase 2-flop synchroniser with an optional glitch filter (QDEC_GLITCH_FILTER_EN).
module qdec_sync_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level
);

    logic r_sync1;
    logic r_sync2;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int HW = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;

    logic [HW-1:0] r_hist;
    logic          r_held;
    logic [HW:0]   w_shift;
    logic          w_stable;
    logic          w_level;

    // The newest synced sample plus HW older ones must agree before the level moves.
    always_comb begin
        w_shift  = {r_hist, r_sync2};
        w_stable = (FILTER_LEN <= 1) || (w_shift == {(HW + 1){r_sync2}});
        if (w_stable) begin
            w_level = r_sync2;
        end else begin
            w_level = r_held;
        end
    end

    // Sample history and last accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= {HW{1'b0}};
            r_held <= 1'b0;
        end else begin
            r_hist <= w_shift[HW-1:0];
            r_held <= w_level;
        end
    end

    assign o_level = w_level;
`else
    assign o_level = r_sync2;
`endif

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B to step/up pulses with wrap-around position and illegal-transition flag.
// Optional glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quadrature_step_decoder
    import qdec_pkg::*;
#(
    parameter int POS_W      = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             enable,
    output logic             step,
    output logic             up,
    output logic             err,
    output logic [POS_W-1:0] position
);

    logic             w_a;
    logic             w_b;
    logic [1:0]       w_ab;
    tr_e              w_tr;
    logic [1:0]       r_prev_ab;
    logic             r_primed;
    logic             r_step;
    logic             r_up;
    logic             r_err;
    logic [POS_W-1:0] r_pos;

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W - 1){1'b0}}, 1'b1};

    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (quad_a),
        .o_level (w_a)
    );

    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (quad_b),
        .o_level (w_b)
    );

    assign w_ab = {w_a, w_b};
    assign w_tr = classify(r_prev_ab, w_ab);

    // Decode against the previous accepted sample; the first sample after reset only primes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_ab <= PH_00;
            r_primed  <= 1'b0;
            r_step    <= 1'b0;
            r_up      <= 1'b0;
            r_err     <= 1'b0;
            r_pos     <= {POS_W{1'b0}};
        end else begin
            r_prev_ab <= w_ab;
            r_primed  <= 1'b1;
            r_step    <= 1'b0;
            r_up      <= 1'b0;
            r_err     <= 1'b0;
            if (r_primed) begin
                case (w_tr)
                    TR_FWD: begin
                        if (enable) begin
                            r_step <= 1'b1;
                            r_up   <= 1'b1;
                            r_pos  <= r_pos + POS_ONE;
                        end
                    end
                    TR_REV: begin
                        if (enable) begin
                            r_step <= 1'b1;
                            r_pos  <= r_pos - POS_ONE;
                        end
                    end
                    TR_ILLEGAL: r_err <= 1'b1;
                    default:    r_err <= 1'b0;
                endcase
            end
        end
    end

    assign step     = r_step;
    assign up       = r_up;
    assign err      = r_err;
    assign position = r_pos;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed self-checking bench for quadrature_step_decoder (POS_W=4); honours QDEC_GLITCH_FILTER_EN.
module tb_quadrature_step_decoder;

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       quad_a;
    logic       quad_b;
    logic       enable;
    logic       step;
    logic       up;
    logic       err;
    logic [3:0] position;

    int n_checks = 0;
    int n_errors = 0;

    quadrature_step_decoder #(.POS_W(4), .FILTER_LEN(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .quad_a   (quad_a),
        .quad_b   (quad_b),
        .enable   (enable),
        .step     (step),
        .up       (up),
        .err      (err),
        .position (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new AB level, then watch LAT+1 cycles: one event exactly at LAT, quiet otherwise.
    task automatic drive_expect(input logic [1:0] ab, input logic e_step, input logic e_up,
                                input logic e_err, input logic [3:0] pos_before,
                                input logic [3:0] pos_after, input string tag);
        @(negedge clk);
        {quad_a, quad_b} = ab;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT) begin
                check({tag, ".step"}, {31'd0, step}, {31'd0, e_step});
                check({tag, ".up"},   {31'd0, up},   {31'd0, e_up});
                check({tag, ".err"},  {31'd0, err},  {31'd0, e_err});
                check({tag, ".pos"},  {28'd0, position}, {28'd0, pos_after});
            end else begin
                check({tag, ".idle_step"}, {31'd0, step}, 32'd0);
                check({tag, ".idle_err"},  {31'd0, err},  32'd0);
                check({tag, ".idle_pos"},  {28'd0, position},
                      {28'd0, (k < LAT) ? pos_before : pos_after});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        quad_a = 1'b0;
        quad_b = 1'b0;

        // T1: reset with toggling pins, then release at 00; first sample must stay silent.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            quad_a = ~quad_a;
            quad_b = (i == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            check("rst.step", {31'd0, step}, 32'd0);
            check("rst.err",  {31'd0, err},  32'd0);
            check("rst.pos",  {28'd0, position}, 32'd0);
        end
        @(negedge clk);
        quad_a = 1'b0;
        quad_b = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk);
            #1;
            check("prime.step", {31'd0, step}, 32'd0);
            check("prime.err",  {31'd0, err},  32'd0);
        end

        // T2: forward 00,01,11,10,00.
        drive_expect(2'b01, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, "fwd1");
        drive_expect(2'b11, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2, "fwd2");
        drive_expect(2'b10, 1'b1, 1'b1, 1'b0, 4'd2, 4'd3, "fwd3");
        drive_expect(2'b00, 1'b1, 1'b1, 1'b0, 4'd3, 4'd4, "fwd4");

        // Mid-run reset clears position on the next cycle.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.pos",  {28'd0, position}, 32'd0);
        check("midrst.step", {31'd0, step}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) @(posedge clk);

        // T3: reverse from 0 with wrap.
        drive_expect(2'b10, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, "rev1");
        drive_expect(2'b11, 1'b1, 1'b0, 1'b0, 4'd15, 4'd14, "rev2");
        drive_expect(2'b01, 1'b1, 1'b0, 1'b0, 4'd14, 4'd13, "rev3");
        drive_expect(2'b00, 1'b1, 1'b0, 1'b0, 4'd13, 4'd12, "rev4");

        // T4: illegal double change, then a normal forward step.
        drive_expect(2'b11, 1'b0, 1'b0, 1'b1, 4'd12, 4'd12, "illegal");
        drive_expect(2'b10, 1'b1, 1'b1, 1'b0, 4'd12, 4'd13, "post_ill");

        // T5: disabled tracking, then exactly one step on re-enable.
        enable = 1'b0;
        drive_expect(2'b00, 1'b0, 1'b0, 1'b0, 4'd13, 4'd13, "dis1");
        drive_expect(2'b01, 1'b0, 1'b0, 1'b0, 4'd13, 4'd13, "dis2");
        drive_expect(2'b11, 1'b0, 1'b0, 1'b0, 4'd13, 4'd13, "dis3");
        enable = 1'b1;
        drive_expect(2'b10, 1'b1, 1'b1, 1'b0, 4'd13, 4'd14, "reen");
        drive_expect(2'b00, 1'b1, 1'b1, 1'b0, 4'd14, 4'd15, "fwd15");

        // T6: one-cycle glitch on B from 00.
        @(negedge clk);
        quad_b = 1'b1;
        @(negedge clk);
        quad_b = 1'b0;
`ifdef QDEC_GLITCH_FILTER_EN
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk);
            #1;
            check("glitch.step", {31'd0, step}, 32'd0);
            check("glitch.err",  {31'd0, err},  32'd0);
            check("glitch.pos",  {28'd0, position}, 32'd15);
        end
        drive_expect(2'b01, 1'b1, 1'b1, 1'b0, 4'd15, 4'd0, "held_b");
`else
        // Pin high from the first negedge: forward pulse on cycle 3, reverse on cycle 4.
        @(posedge clk);
        #1;
        check("glitch.c1", {31'd0, step}, 32'd0);
        @(posedge clk);
        #1;
        check("glitch.fstep", {31'd0, step}, 32'd1);
        check("glitch.fup",   {31'd0, up},   32'd1);
        check("glitch.fpos",  {28'd0, position}, 32'd0);
        @(posedge clk);
        #1;
        check("glitch.rstep", {31'd0, step}, 32'd1);
        check("glitch.rup",   {31'd0, up},   32'd0);
        check("glitch.rpos",  {28'd0, position}, 32'd15);
        @(posedge clk);
        #1;
        check("glitch.quiet", {31'd0, step}, 32'd0);
        check("glitch.err",   {31'd0, err},  32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
